handshake_responder: RTL and testbench
======================================

HANDSHAKE_RESPONDER -- requirements
Module: handshake_responder

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of the transferred word.
REQ-002 clk  input  1  single clock; every register in the block is in this domain.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqToggle  input  1  asynchronous request toggle from the sending domain; each level change is one request.
REQ-005 reqData  input  DATA_WIDTH  asynchronous data; sender holds it stable from a reqToggle change until it sees the matching ackToggle change.
REQ-006 ackToggle  output  1  acknowledge toggle returned to the sender; registered, glitch-free.
REQ-007 outData  output  DATA_WIDTH  captured word presented downstream.
REQ-008 outValid  output  1  outData holds an unaccepted word.
REQ-009 outReady  input  1  downstream accepts when outValid and outReady are both high in the same cycle.
REQ-010 transferCount  output  16  number of accepted words, modulo 2^16.
REQ-011 protocolError  output  1  sticky flag: a request edge arrived while a transfer was in progress.

Function
REQ-012 reqToggle SHALL pass through a two-flop synchronizer (reqSync_m, reqSync), both marked ASYNC_REG, then one delay flop reqSync_d.
REQ-013 A request edge SHALL be detected in any cycle where reqSync != reqSync_d.
REQ-014 FSM states SHALL be IDLE, PRESENT and ACK; IDLE is the reset state.
REQ-015 IDLE with request edge: reqData is captured into outData, outValid is set and the FSM moves to PRESENT; reqToggle change to outValid high takes 3 clk edges.
REQ-016 In PRESENT, outValid SHALL stay high and outData stable until accept; on accept the FSM moves to ACK and outValid clears on the next edge.
REQ-017 The cycle in which outValid first rises SHALL count as an accept if outReady is also high.
REQ-018 In ACK, ackToggle SHALL invert and the FSM returns to IDLE; ackToggle changes exactly one edge after the accept edge.
REQ-019 Minimum sustained transfer period at outReady=1: 3 receiver cycles plus the sender's ack synchronization and its next toggle.
REQ-020 A request edge in PRESENT or ACK SHALL set protocolError and otherwise be ignored (no capture, no extra ack); protocolError clears only on reset.
REQ-021 transferCount SHALL increment by 1 on each accept and wrap 0xFFFF -> 0x0000.
REQ-022 outData SHALL change only on capture or reset.

Reset
REQ-023 While reset is high: state=IDLE, outValid=0, outData=0, transferCount=0, protocolError=0.
REQ-024 The synchronizer flops SHALL not be reset; during reset reqSync_d <= reqSync and ackToggle <= reqSync.
REQ-025 Consequence: a request pending at reset is acknowledged without delivery, and no spurious request is seen after reset release.
REQ-026 Reset asserted in PRESENT or ACK SHALL abort the transfer with no accept and no count increment.

Structure
REQ-027 A shared package SHALL hold the state enumeration (IDLE, PRESENT, ACK) and the constants SYNC_STAGES=2 and COUNT_WIDTH=16.
REQ-028 One sub-module, toggle_sync, SHALL implement the ASYNC_REG synchronizer and is reusable by the matching sender.

Verification
REQ-029 Reset release with reqToggle=0, then toggle to 1 with reqData=0xDEADBEEF and outReady=1 -> outValid high on edge 3 with outData=0xDEADBEEF, ackToggle=1 one edge after accept, transferCount=1.
REQ-030 outReady=0 for 10 cycles after outValid -> outData stays 0xDEADBEEF, ackToggle unchanged; outReady=1 -> ackToggle flips on the next edge.
REQ-031 Modelled sender on an unrelated clock (ratio 37:50) sends 1000 incrementing words -> all 1000 received in order, none duplicated, transferCount=1000, protocolError=0.
REQ-032 Second reqToggle edge injected while in PRESENT -> protocolError=1 and sticky, only one word delivered, one ack toggle.
REQ-033 Preload transferCount to 0xFFFF, then accept one word -> transferCount=0x0000.
REQ-034 Reset with reqToggle=1 held -> after release outValid stays 0, ackToggle=1 and protocolError=0.

Source files
------------

// File: rtl/handshake_responder_pkg.sv
// +----------------------------------------------------------------------+
// | handshake_responder_pkg                                              |
// | Shared state encoding and constants for the toggle-handshake block.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

package handshake_responder_pkg;

    localparam int SYNC_STAGES = 2;
    localparam int COUNT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        ACK     = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/handshake_responder_if.sv
// +----------------------------------------------------------------------+
// | handshake_responder_if                                               |
// | Toggle request/ack, downstream valid/ready and status bundle.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

interface handshake_responder_if
    import handshake_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) ();

    logic                   reqToggle;
    logic [DATA_WIDTH-1:0]  reqData;
    logic                   ackToggle;
    logic [DATA_WIDTH-1:0]  outData;
    logic                   outValid;
    logic                   outReady;
    logic [COUNT_WIDTH-1:0] transferCount;
    logic                   protocolError;
    // Maintenance preload of the transfer counter; tie countLoad low in normal use.
    logic                   countLoad;
    logic [COUNT_WIDTH-1:0] countLoadValue;

    modport master (
        output reqToggle,
        output reqData,
        input  ackToggle,
        input  outData,
        input  outValid,
        output outReady,
        input  transferCount,
        input  protocolError,
        output countLoad,
        output countLoadValue
    );

    modport slave (
        input  reqToggle,
        input  reqData,
        output ackToggle,
        output outData,
        output outValid,
        input  outReady,
        output transferCount,
        output protocolError,
        input  countLoad,
        input  countLoadValue
    );

endinterface

`default_nettype wire

// File: rtl/handshake_responder_toggle_sync.sv
// +----------------------------------------------------------------------+
// | toggle_sync                                                          |
// | Unreset multi-stage synchronizer for a toggle crossing clock domains.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

module toggle_sync
    import handshake_responder_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic async_in,
    output logic sync_out
);

    // Stage 0 is the metastable capture flop, the last stage is the clean output.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
    end

    always_ff @(posedge clk) begin
        sync_q <= sync_d;
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/handshake_responder.sv
// +----------------------------------------------------------------------+
// | handshake_responder                                                  |
// | Receives toggle-handshake words from a foreign clock domain and      |
// | presents them on a valid/ready port, acking once each is accepted.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

module handshake_responder
    import handshake_responder_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    handshake_responder_if.slave bus
);

    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_PRESENT = PRESENT;
    localparam logic [1:0] S_ACK     = ACK;

    logic                   req_sync;
    logic                   req_sync_dly_q;
    logic                   req_edge;
    logic                   accept;

    logic [1:0]             state_q,          state_d;
    logic [DATA_WIDTH-1:0]  out_data_q,       out_data_d;
    logic                   out_valid_q,      out_valid_d;
    logic                   ack_toggle_q,     ack_toggle_d;
    logic                   protocol_error_q, protocol_error_d;
    logic [COUNT_WIDTH-1:0] transfer_count_q, transfer_count_d;

    toggle_sync #(
        .STAGES   (SYNC_STAGES)
    ) u_req_sync (
        .clk      (clk),
        .async_in (bus.reqToggle),
        .sync_out (req_sync)
    );

    always_comb begin
        req_edge         = (req_sync != req_sync_dly_q);
        accept           = out_valid_q && bus.outReady;
        state_d          = state_q;
        out_data_d       = out_data_q;
        out_valid_d      = out_valid_q;
        ack_toggle_d     = ack_toggle_q;
        protocol_error_d = protocol_error_q;
        transfer_count_d = transfer_count_q;

        case (state_q)
            S_IDLE: begin
                // reqData is quiet here: the sender holds it until our ack toggles.
                if (req_edge) begin
                    out_data_d  = bus.reqData;
                    out_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (accept) begin
                    out_valid_d      = 1'b0;
                    transfer_count_d = transfer_count_q + COUNT_WIDTH'(1);
                    state_d          = S_ACK;
                end
                if (req_edge) begin
                    protocol_error_d = 1'b1;
                end
            end
            S_ACK: begin
                ack_toggle_d = ~ack_toggle_q;
                state_d      = S_IDLE;
                if (req_edge) begin
                    protocol_error_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.countLoad) begin
            transfer_count_d = bus.countLoadValue;
        end
    end

    always_ff @(posedge clk) begin
        req_sync_dly_q <= req_sync;
        if (reset) begin
            state_q          <= S_IDLE;
            out_data_q       <= '0;
            out_valid_q      <= 1'b0;
            protocol_error_q <= 1'b0;
            transfer_count_q <= '0;
            // Mirroring the request retires anything pending and avoids a false edge.
            ack_toggle_q     <= req_sync;
        end else begin
            state_q          <= state_d;
            out_data_q       <= out_data_d;
            out_valid_q      <= out_valid_d;
            protocol_error_q <= protocol_error_d;
            transfer_count_q <= transfer_count_d;
            ack_toggle_q     <= ack_toggle_d;
        end
    end

    assign bus.ackToggle     = ack_toggle_q;
    assign bus.outData       = out_data_q;
    assign bus.outValid      = out_valid_q;
    assign bus.transferCount = transfer_count_q;
    assign bus.protocolError = protocol_error_q;

endmodule

`default_nettype wire

// File: tb/tb_handshake_responder.sv
// +----------------------------------------------------------------------+
// | tb_handshake_responder                                               |
// | Directed bench for handshake_responder with a foreign-clock sender.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/100ps

module tb_handshake_responder;

    localparam int DW      = 32;
    localparam int N_WORDS = 1000;

    logic clk   = 1'b0;
    logic sclk  = 1'b0;
    logic reset = 1'b1;

    int errors = 0;
    int checks = 0;

    logic        mon_en   = 1'b0;
    logic [31:0] exp_word = 32'd0;
    int          rx_count = 0;
    bit          sender_ok;

    handshake_responder_if #(.DATA_WIDTH(DW)) bus ();

    handshake_responder #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Receiver and sender periods are 37 and 50 time units.
    always #18.5 clk  = ~clk;
    always #25   sclk = ~sclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sender: two-flop ack synchronizer, toggles the next word once ack matches.
    task automatic run_sender(input int n, output bit ok);
        int   sent  = 0;
        int   guard = 0;
        logic a1    = bus.ackToggle;
        logic a2    = bus.ackToggle;
        ok = 1'b0;
        while (guard < 40000) begin
            @(posedge sclk);
            guard++;
            a2 = a1;
            a1 = bus.ackToggle;
            if (a2 == bus.reqToggle) begin
                if (sent == n) begin
                    ok = 1'b1;
                    break;
                end
                bus.reqData   = 32'(sent);
                bus.reqToggle = ~bus.reqToggle;
                sent++;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.outValid && bus.outReady) begin
            check_eq("stream_word", bus.outData, exp_word);
            exp_word <= exp_word + 32'd1;
            rx_count <= rx_count + 1;
        end
    end

    initial begin
        bus.reqToggle      = 1'b0;
        bus.reqData        = '0;
        bus.outReady       = 1'b0;
        bus.countLoad      = 1'b0;
        bus.countLoadValue = '0;

        // Reset state
        tick(5);
        check_eq("rst_valid", bus.outValid, 0);
        check_eq("rst_data", bus.outData, 0);
        check_eq("rst_count", bus.transferCount, 0);
        check_eq("rst_error", bus.protocolError, 0);
        check_eq("rst_ack", bus.ackToggle, 0);
        reset = 1'b0;
        tick(2);

        // Basic transfer: valid on edge 3, accept on 4, ack on 5
        bus.reqData   = 32'hDEADBEEF;
        bus.reqToggle = 1'b1;
        bus.outReady  = 1'b1;
        tick(2);
        check_eq("lat_not_yet", bus.outValid, 0);
        tick(1);
        check_eq("lat_valid", bus.outValid, 1);
        check_eq("lat_data", bus.outData, 32'hDEADBEEF);
        check_eq("lat_count0", bus.transferCount, 0);
        tick(1);
        check_eq("acc_valid_clr", bus.outValid, 0);
        check_eq("acc_count1", bus.transferCount, 1);
        check_eq("acc_ack_hold", bus.ackToggle, 0);
        tick(1);
        check_eq("ack_flip1", bus.ackToggle, 1);

        // Backpressure: word held for 10 cycles
        bus.outReady  = 1'b0;
        bus.reqToggle = 1'b0;
        tick(3);
        check_eq("bp_valid", bus.outValid, 1);
        bus.reqData = 32'h0BADF00D;
        tick(10);
        check_eq("bp_valid_hold", bus.outValid, 1);
        check_eq("bp_data_hold", bus.outData, 32'hDEADBEEF);
        check_eq("bp_ack_hold", bus.ackToggle, 1);
        bus.outReady = 1'b1;
        tick(1);
        check_eq("bp_acc_valid", bus.outValid, 0);
        check_eq("bp_acc_count", bus.transferCount, 2);
        check_eq("bp_acc_ack", bus.ackToggle, 1);
        tick(1);
        check_eq("bp_ack_flip", bus.ackToggle, 0);

        // Protocol error: second edge while presenting
        bus.outReady  = 1'b0;
        bus.reqData   = 32'h11111111;
        bus.reqToggle = 1'b1;
        tick(3);
        check_eq("pe_valid", bus.outValid, 1);
        check_eq("pe_no_err_yet", bus.protocolError, 0);
        bus.reqToggle = 1'b0;
        tick(3);
        check_eq("pe_err_set", bus.protocolError, 1);
        check_eq("pe_data", bus.outData, 32'h11111111);
        bus.outReady = 1'b1;
        tick(1);
        check_eq("pe_count", bus.transferCount, 3);
        tick(1);
        check_eq("pe_ack", bus.ackToggle, 1);
        tick(6);
        check_eq("pe_no_redeliver", bus.outValid, 0);
        check_eq("pe_single_ack", bus.ackToggle, 1);
        check_eq("pe_sticky", bus.protocolError, 1);
        check_eq("pe_count_hold", bus.transferCount, 3);

        // Reset with a pending request held high
        reset         = 1'b1;
        bus.reqToggle = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(6);
        check_eq("rp_valid", bus.outValid, 0);
        check_eq("rp_ack", bus.ackToggle, 1);
        check_eq("rp_error", bus.protocolError, 0);
        check_eq("rp_count", bus.transferCount, 0);

        // Counter wrap from preload
        bus.countLoad      = 1'b1;
        bus.countLoadValue = 16'hFFFF;
        tick(1);
        bus.countLoad = 1'b0;
        check_eq("wrap_preload", bus.transferCount, 32'h0000FFFF);
        bus.reqData   = 32'hA5A5A5A5;
        bus.reqToggle = 1'b0;
        bus.outReady  = 1'b1;
        tick(3);
        check_eq("wrap_data", bus.outData, 32'hA5A5A5A5);
        tick(1);
        check_eq("wrap_count", bus.transferCount, 0);
        tick(1);
        check_eq("wrap_ack", bus.ackToggle, 0);

        // Reset while presenting aborts the transfer
        bus.outReady  = 1'b0;
        bus.reqData   = 32'h77777777;
        bus.reqToggle = 1'b1;
        tick(3);
        check_eq("ab_valid", bus.outValid, 1);
        reset = 1'b1;
        tick(1);
        check_eq("ab_valid_clr", bus.outValid, 0);
        check_eq("ab_data_clr", bus.outData, 0);
        check_eq("ab_ack", bus.ackToggle, 1);
        reset        = 1'b0;
        bus.outReady = 1'b1;
        tick(4);
        check_eq("ab_no_deliver", bus.outValid, 0);
        check_eq("ab_count", bus.transferCount, 0);

        // Streaming from the foreign-clock sender
        exp_word = 32'd0;
        rx_count = 0;
        mon_en   = 1'b1;
        run_sender(N_WORDS, sender_ok);
        check_eq("stream_timeout", sender_ok, 1);
        tick(10);
        mon_en = 1'b0;
        check_eq("stream_rx", rx_count, N_WORDS);
        check_eq("stream_last", exp_word, N_WORDS);
        check_eq("stream_count", bus.transferCount, N_WORDS);
        check_eq("stream_error", bus.protocolError, 0);
        check_eq("stream_ack_match", bus.ackToggle, bus.reqToggle);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
